sum_pair_driver: RTL and testbench

- Stimulus transmitter and checker for a 1-bit registered-sum responder that uses a valid/ready handshake on operand ports.
- Generates pseudo-random operand pairs from an LFSR and drives them out under the handshake.
- Samples the responder's registered result and counts mismatches.
- Sits in the timing-coverage netlists as the upstream driver, giving the port/path constraints a real launch/capture partner.

---
 rtl/sum_pair_driver_if.sv | 25 ++
 rtl/sum_pair_driver.sv | 125 ++++++++++++
 tb/tb_sum_pair_driver.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_pair_driver_if.sv
// Operand/result handshake between the stimulus driver and a 1-bit registered-sum responder.
// A transfer is valid_out & ready_in at a rising clock edge.
interface sum_pair_driver_if;
    logic data1_out;
    logic data2_out;
    logic valid_out;
    logic ready_in;
    logic result_in;

    modport master (
        output data1_out,
        output data2_out,
        output valid_out,
        input  ready_in,
        input  result_in
    );

    modport slave (
        input  data1_out,
        input  data2_out,
        input  valid_out,
        output ready_in,
        output result_in
    );
endinterface

// File: rtl/sum_pair_driver.sv
// Sends LFSR-generated operand pairs to a registered-sum responder and counts wrong results.
// All outputs are decoded from registered state, so nothing combinational reaches them from inputs.
module sum_pair_driver #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_in,
    sum_pair_driver_if.master       bus,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    pass_out,
    output logic [7:0]              err_count_out,
    output logic [15:0]             vec_count_out
);

    localparam logic [15:0] NumVec  = 16'(NUM_VECTORS);
    localparam logic [7:0]  GapLast = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSend, StCheck, StGap, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        exp_q, exp_d;
    logic [7:0]  err_q, err_d;
    logic [15:0] vec_q, vec_d;
    logic [7:0]  gap_q, gap_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_in) state_d = StSend;
            end
            StSend: begin
                if (bus.ready_in) state_d = StCheck;
            end
            StCheck: begin
                if (vec_q + 16'd1 == NumVec) begin
                    state_d = StDone;
                end else if (GAP_CYCLES > 0) begin
                    state_d = StGap;
                end else begin
                    state_d = StSend;
                end
            end
            StGap: begin
                if (gap_q == GapLast) state_d = StSend;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            exp_q  <= 1'b0;
            err_q  <= 8'd0;
            vec_q  <= 16'd0;
            gap_q  <= 8'd0;
        end else begin
            lfsr_q <= lfsr_d;
            exp_q  <= exp_d;
            err_q  <= err_d;
            vec_q  <= vec_d;
            gap_q  <= gap_d;
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        exp_d  = exp_q;
        err_d  = err_q;
        vec_d  = vec_q;
        gap_d  = gap_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_in) begin
                    lfsr_d = LFSR_SEED;
                    err_d  = 8'd0;
                    vec_d  = 16'd0;
                end
            end
            StSend: begin
                if (bus.ready_in) begin
                    exp_d  = lfsr_q[0] ^ lfsr_q[1];
                    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                end
            end
            StCheck: begin
                vec_d = vec_q + 16'd1;
                gap_d = 8'd0;
                // Saturate so a badly broken responder still reads as "many" errors.
                if ((bus.result_in != exp_q) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
            end
            StGap: begin
                gap_d = gap_q + 8'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.valid_out = (state_q == StSend);
        // Operands are masked outside SEND so every output reads 0 while idle or in reset.
        bus.data1_out = bus.valid_out & lfsr_q[0];
        bus.data2_out = bus.valid_out & lfsr_q[1];
        busy_out      = (state_q == StSend) || (state_q == StCheck) || (state_q == StGap);
        done_out      = (state_q == StDone);
        pass_out      = (state_q == StDone) && (err_q == 8'd0);
        err_count_out = err_q;
        vec_count_out = vec_q;
    end

endmodule

// File: tb/tb_sum_pair_driver.sv
// Bench for sum_pair_driver: table of run scenarios against a sequence/scoreboard model, plus
// hand-written sequences for backpressure, gaps, saturation, reset mid-run and restart.
module tb_sum_pair_driver;

    localparam int NA = 4;
    localparam int NB = 4;
    localparam int GB = 3;
    localparam int NC = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Instance A: N=4, no gap, bench-controlled responder behaviour.
    sum_pair_driver_if ifa ();
    logic        start_a = 1'b0, ready_a = 1'b0, resp_a, flip_a = 1'b0;
    int          mode_a = 0;
    logic        busy_a, done_a, pass_a;
    logic [7:0]  err_a;
    logic [15:0] vec_a;
    assign ifa.ready_in  = ready_a;
    assign ifa.result_in = resp_a;

    sum_pair_driver #(.NUM_VECTORS(NA), .LFSR_SEED(8'hA5), .GAP_CYCLES(0)) u_a (
        .clk(clk), .rst(rst), .start_in(start_a), .bus(ifa.master),
        .busy_out(busy_a), .done_out(done_a), .pass_out(pass_a),
        .err_count_out(err_a), .vec_count_out(vec_a)
    );

    // Responder modes: 0 correct, 1 stuck at 0, 2 inverted, 3 randomly corrupted via flip_a.
    always @(posedge clk or posedge rst) begin
        if (rst) resp_a <= 1'b0;
        else if (ifa.valid_out && ifa.ready_in) begin
            case (mode_a)
                1:       resp_a <= 1'b0;
                2:       resp_a <= ~(ifa.data1_out ^ ifa.data2_out);
                3:       resp_a <= ifa.data1_out ^ ifa.data2_out ^ flip_a;
                default: resp_a <= ifa.data1_out ^ ifa.data2_out;
            endcase
        end
    end

    // Instance B: gaps between vectors, correct responder.
    sum_pair_driver_if ifb ();
    logic        start_b = 1'b0, resp_b;
    logic        busy_b, done_b, pass_b;
    logic [7:0]  err_b;
    logic [15:0] vec_b;
    assign ifb.ready_in  = 1'b1;
    assign ifb.result_in = resp_b;
    always @(posedge clk or posedge rst) begin
        if (rst) resp_b <= 1'b0;
        else if (ifb.valid_out && ifb.ready_in) resp_b <= ifb.data1_out ^ ifb.data2_out;
    end

    sum_pair_driver #(.NUM_VECTORS(NB), .LFSR_SEED(8'hA5), .GAP_CYCLES(GB)) u_b (
        .clk(clk), .rst(rst), .start_in(start_b), .bus(ifb.master),
        .busy_out(busy_b), .done_out(done_b), .pass_out(pass_b),
        .err_count_out(err_b), .vec_count_out(vec_b)
    );

    // Instance C: long run with an inverting responder to reach error saturation.
    sum_pair_driver_if ifc ();
    logic        start_c = 1'b0, resp_c;
    logic        busy_c, done_c, pass_c;
    logic [7:0]  err_c;
    logic [15:0] vec_c;
    assign ifc.ready_in  = 1'b1;
    assign ifc.result_in = resp_c;
    always @(posedge clk or posedge rst) begin
        if (rst) resp_c <= 1'b0;
        else if (ifc.valid_out && ifc.ready_in) resp_c <= ~(ifc.data1_out ^ ifc.data2_out);
    end

    sum_pair_driver #(.NUM_VECTORS(NC), .LFSR_SEED(8'hA5), .GAP_CYCLES(0)) u_c (
        .clk(clk), .rst(rst), .start_in(start_c), .bus(ifc.master),
        .busy_out(busy_c), .done_out(done_c), .pass_out(pass_c),
        .err_count_out(err_c), .vec_count_out(vec_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    typedef struct {
        int mode;        // responder mode
        int ready_pct;   // chance ready_in is high in a cycle
        int stall;       // ready_in held low for this many cycles on the first SEND
        bit hold_start;  // keep start_in high during the run
        int exp_err;     // expected err_count_out, -1 = use scoreboard
    } run_t;

    run_t tbl[6];

    // One run on instance A. Operands follow the seed sequence, advancing only on a transfer;
    // each SEND with ready_in low costs one extra edge on top of two edges per vector.
    task automatic run_a(input run_t v);
        logic [7:0] s = 8'hA5;
        int vidx = 0, edges = 0, waits = 0, sb_err = 0, stalled = 0, exp_err;
        logic x, r;
        mode_a = v.mode;
        @(negedge clk);
        start_a = 1'b1;
        ready_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = v.hold_start;
        check("start_busy", busy_a, 1);
        check("start_done_clear", done_a, 0);
        check("start_vec_clear", vec_a, 0);
        check("start_err_clear", err_a, 0);
        while (!done_a && edges < 3000) begin
            if (edges >= 5) start_a = 1'b0;
            if (ifa.valid_out) begin
                check("data1", ifa.data1_out, s[0]);
                check("data2", ifa.data2_out, s[1]);
            end
            if (vidx == 0 && stalled < v.stall) begin
                check("stall_valid", ifa.valid_out, 1);
                ready_a = 1'b0;
                stalled++;
            end else begin
                ready_a = ($urandom_range(0, 99) < v.ready_pct);
            end
            flip_a = 1'($urandom_range(0, 1));
            if (ifa.valid_out && ready_a) begin
                x = s[0] ^ s[1];
                case (v.mode)
                    1:       r = 1'b0;
                    2:       r = ~x;
                    3:       r = x ^ flip_a;
                    default: r = x;
                endcase
                if (r != x) sb_err++;
                s = lfsr_step(s);
                vidx++;
            end else if (ifa.valid_out) begin
                waits++;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start_a = 1'b0;
        exp_err = (v.exp_err >= 0) ? v.exp_err : ((sb_err > 255) ? 255 : sb_err);
        check("done", done_a, 1);
        check("busy_end", busy_a, 0);
        check("vectors_sent", vidx, NA);
        check("edges_to_done", edges, 2 * NA + waits);
        check("err_count", err_a, exp_err);
        check("pass", pass_a, exp_err == 0);
        check("vec_count", vec_a, NA);
        repeat (3) @(negedge clk);
        check("done_held", done_a, 1);
        check("vec_held", vec_a, NA);
    endtask

    initial begin
        // Vectors from seed A5 all have data1^data2 = 1, so a stuck-at-0 responder misses all 4.
        tbl[0] = '{mode: 0, ready_pct: 100, stall: 0, hold_start: 0, exp_err: 0};
        tbl[1] = '{mode: 0, ready_pct: 100, stall: 5, hold_start: 0, exp_err: 0};
        tbl[2] = '{mode: 1, ready_pct: 100, stall: 0, hold_start: 1, exp_err: 4};
        tbl[3] = '{mode: 2, ready_pct: 60,  stall: 0, hold_start: 0, exp_err: 4};
        tbl[4] = '{mode: 3, ready_pct: 50,  stall: 2, hold_start: 1, exp_err: -1};
        tbl[5] = '{mode: 0, ready_pct: 30,  stall: 0, hold_start: 0, exp_err: 0};

        #2;
        check("rst_valid", ifa.valid_out, 0);
        check("rst_data1", ifa.data1_out, 0);
        check("rst_data2", ifa.data2_out, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_vec", vec_a, 0);
        @(negedge clk);
        rst = 1'b0;

        // Runs after the first also exercise restart from DONE.
        for (int i = 0; i < 6; i++) run_a(tbl[i]);

        // Reset while the second vector is being offered.
        mode_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        ready_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        check("v1_data1", ifa.data1_out, 1);
        check("v1_data2", ifa.data2_out, 0);
        repeat (2) @(negedge clk);
        check("v2_valid", ifa.valid_out, 1);
        check("v2_data1", ifa.data1_out, 0);
        check("v2_data2", ifa.data2_out, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", ifa.valid_out, 0);
        check("midrst_data1", ifa.data1_out, 0);
        check("midrst_data2", ifa.data2_out, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_vec", vec_a, 0);
        check("midrst_err", err_a, 0);
        @(negedge clk);
        rst = 1'b0;
        run_a(tbl[0]);

        // Gaps: CHECK plus GB idle cycles between vectors, none after the last one.
        begin
            int edges = 0, lowrun = 0, highs = 0;
            @(negedge clk);
            start_b = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_b = 1'b0;
            while (!done_b && edges < 500) begin
                if (ifb.valid_out) begin
                    if (highs > 0) check("gap_low_run", lowrun, 1 + GB);
                    highs++;
                    lowrun = 0;
                end else begin
                    lowrun++;
                end
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            check("gap_done", done_b, 1);
            check("gap_transfers", highs, NB);
            check("gap_edges", edges, 2 * NB + GB * (NB - 1));
            check("gap_pass", pass_b, 1);
            check("gap_vec", vec_b, NB);
        end

        // Saturation: every one of 300 results is wrong.
        begin
            int edges = 0;
            @(negedge clk);
            start_c = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_c = 1'b0;
            while (!done_c && edges < 2000) begin
                @(negedge clk);
                edges++;
            end
            check("sat_done", done_c, 1);
            check("sat_err", err_c, 255);
            check("sat_vec", vec_c, NC);
            check("sat_pass", pass_c, 0);
            check("sat_edges", edges, 2 * NC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
